// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: result sources, stage shadow record, forwarding select codes.
package hazard_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_PC8 = 2'd1,
        RES_MEM = 2'd2,
        RES_MD  = 2'd3
    } res_src_t;

    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
        res_src_t   res;
    } stage_t;

    localparam logic [2:0] SEL_D_GRF  = 3'd0;
    localparam logic [2:0] SEL_D_PCE8 = 3'd1;
    localparam logic [2:0] SEL_D_PCM8 = 3'd2;
    localparam logic [2:0] SEL_D_ALUM = 3'd3;
    localparam logic [2:0] SEL_D_PCW8 = 3'd4;
    localparam logic [2:0] SEL_D_WDW  = 3'd5;
    localparam logic [2:0] SEL_D_MDE  = 3'd6;
    localparam logic [2:0] SEL_D_MDM  = 3'd7;

    localparam logic [2:0] SEL_E_PIPE = 3'd0;
    localparam logic [2:0] SEL_E_PCM8 = 3'd1;
    localparam logic [2:0] SEL_E_ALUM = 3'd2;
    localparam logic [2:0] SEL_E_PCW8 = 3'd3;
    localparam logic [2:0] SEL_E_WDW  = 3'd4;
    localparam logic [2:0] SEL_E_MDM  = 3'd5;

    localparam logic [2:0] SEL_M_PIPE = 3'd0;
    localparam logic [2:0] SEL_M_PCW8 = 3'd1;
    localparam logic [2:0] SEL_M_WDW  = 3'd2;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Mult/div occupancy counter: loads the op latency when a mult/div sits in E, counts down to 0.
// busy is registered (count != 0); a new start reloads the counter even mid-count.
module md_busy_tracker #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (start) begin
            count <= div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forwarding control for a 5-stage pipeline, combinational outputs from E/M/W shadow state.
// Mult/div tracking is compiled in only when HAZARD_MD_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuseRs_D,
    input  logic [1:0] tuseRt_D,
    input  logic [4:0] wa_D,
    input  logic [1:0] tnew_D,
    input  logic [1:0] resSrc_D,
    input  logic       mdStart_D,
    input  logic       mdDiv_D,
    input  logic       mdUse_D,
    output logic       stall,
    output logic [2:0] selRsD,
    output logic [2:0] selRtD,
    output logic [2:0] selRsE,
    output logic [2:0] selRtE,
    output logic [2:0] selRtM,
    output logic       mdBusy
);

`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    stage_t     st_e, st_m, st_w;
    logic [4:0] rs_e, rt_e, rt_m;
    logic       md_stall;

    // The youngest stage writing the register decides; if its value is not yet
    // forwardable the select stays 0 rather than falling back to a stale older copy.
    function automatic logic [2:0] d_code(input logic [4:0] r, input stage_t e, input stage_t m,
                                          input stage_t w);
        logic [2:0] code;
        code = SEL_D_GRF;
        if (r == 5'd0) begin
            code = SEL_D_GRF;
        end else if (r == e.wa) begin
            if (e.tnew == 2'd0 && e.res == RES_PC8)       code = SEL_D_PCE8;
            else if (MD_EN && e.tnew == 2'd0 && e.res == RES_MD) code = SEL_D_MDE;
        end else if (r == m.wa) begin
            if (m.tnew == 2'd0) begin
                case (m.res)
                    RES_ALU: code = SEL_D_ALUM;
                    RES_PC8: code = SEL_D_PCM8;
                    RES_MD:  code = MD_EN ? SEL_D_MDM : SEL_D_GRF;
                    default: code = SEL_D_GRF;
                endcase
            end
        end else if (r == w.wa) begin
            if (w.tnew == 2'd0) code = (w.res == RES_PC8) ? SEL_D_PCW8 : SEL_D_WDW;
        end
        return code;
    endfunction

    function automatic logic [2:0] e_code(input logic [4:0] r, input stage_t m, input stage_t w);
        logic [2:0] code;
        code = SEL_E_PIPE;
        if (r == 5'd0) begin
            code = SEL_E_PIPE;
        end else if (r == m.wa) begin
            if (m.tnew == 2'd0) begin
                case (m.res)
                    RES_ALU: code = SEL_E_ALUM;
                    RES_PC8: code = SEL_E_PCM8;
                    RES_MD:  code = MD_EN ? SEL_E_MDM : SEL_E_PIPE;
                    default: code = SEL_E_PIPE;
                endcase
            end
        end else if (r == w.wa) begin
            if (w.tnew == 2'd0) code = (w.res == RES_PC8) ? SEL_E_PCW8 : SEL_E_WDW;
        end
        return code;
    endfunction

    function automatic logic [2:0] m_code(input logic [4:0] r, input stage_t w);
        logic [2:0] code;
        code = SEL_M_PIPE;
        if (r != 5'd0 && r == w.wa && w.tnew == 2'd0)
            code = (w.res == RES_PC8) ? SEL_M_PCW8 : SEL_M_WDW;
        return code;
    endfunction

    function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse,
                                       input stage_t e, input stage_t m);
        return (r != 5'd0) && (tuse != 2'd3) &&
               (((r == e.wa) && (tuse < e.tnew)) || ((r == m.wa) && (tuse < m.tnew)));
    endfunction

    always_comb begin
        stall  = src_stall(rs_D, tuseRs_D, st_e, st_m) |
                 src_stall(rt_D, tuseRt_D, st_e, st_m) | md_stall;
        selRsD = d_code(rs_D, st_e, st_m, st_w);
        selRtD = d_code(rt_D, st_e, st_m, st_w);
        selRsE = e_code(rs_e, st_m, st_w);
        selRtE = e_code(rt_e, st_m, st_w);
        selRtM = m_code(rt_m, st_w);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_e <= '0;
            st_m <= '0;
            st_w <= '0;
            rs_e <= '0;
            rt_e <= '0;
            rt_m <= '0;
        end else begin
            if (stall) begin
                st_e <= '0;
                rs_e <= '0;
                rt_e <= '0;
            end else begin
                st_e <= '{wa: wa_D, tnew: tnew_D, res: res_src_t'(resSrc_D)};
                rs_e <= rs_D;
                rt_e <= rt_D;
            end
            st_m <= '{wa: st_e.wa, tnew: tnew_dec(st_e.tnew), res: st_e.res};
            rt_m <= rt_e;
            st_w <= '{wa: st_m.wa, tnew: tnew_dec(st_m.tnew), res: st_m.res};
        end
    end

`ifdef HAZARD_MD_EN
    logic md_start_e, md_div_e;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_start_e <= 1'b0;
            md_div_e   <= 1'b0;
        end else begin
            md_start_e <= mdStart_D & ~stall;
            md_div_e   <= mdDiv_D;
        end
    end

    md_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (md_start_e),
        .div     (md_div_e),
        .busy    (mdBusy)
    );

    // HI/LO readers wait for the unit, including the cycle the op itself sits in E.
    assign md_stall = mdUse_D & (mdBusy | md_start_e);
`else
    localparam int unused_md_cycles = MULT_CYCLES + DIV_CYCLES;
    logic unused_md_in;
    assign unused_md_in = ^{mdStart_D, mdDiv_D, mdUse_D};
    assign mdBusy       = 1'b0;
    assign md_stall     = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus randomized traffic vs a timing model.
module tb_hazard_ctrl;

`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    localparam int MULT = 5;
    localparam int DIV  = 10;

    // Forwarding code by producer age (0=E,1=M,2=W) and result source (alu, pc8, mem, md).
    localparam int DTAB [3][4] = '{'{0, 1, 0, 6}, '{3, 2, 0, 7}, '{5, 4, 5, 5}};
    localparam int ETAB [2][4] = '{'{2, 1, 0, 5}, '{4, 3, 4, 4}};
    localparam int MTAB [4]    = '{2, 1, 2, 2};

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rs_D, rt_D, wa_D;
    logic [1:0] tuseRs_D, tuseRt_D, tnew_D, resSrc_D;
    logic       mdStart_D, mdDiv_D, mdUse_D;
    logic       stall, mdBusy;
    logic [2:0] selRsD, selRtD, selRsE, selRtE, selRtM;

    hazard_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs_D(rs_D), .rt_D(rt_D), .tuseRs_D(tuseRs_D), .tuseRt_D(tuseRt_D),
        .wa_D(wa_D), .tnew_D(tnew_D), .resSrc_D(resSrc_D),
        .mdStart_D(mdStart_D), .mdDiv_D(mdDiv_D), .mdUse_D(mdUse_D),
        .stall(stall), .selRsD(selRsD), .selRtD(selRtD), .selRsE(selRsE),
        .selRtE(selRtE), .selRtM(selRtM), .mdBusy(mdBusy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the last three instructions to enter E, indexed by age; a result
    // is forwardable once its age reaches its tnew.
    typedef struct {
        int wa; int tnew; int res; int rs; int rt; bit md; bit dv;
    } ins_t;
    ins_t pipe [3];
    int   now;
    bit   md_set;
    int   md_start, md_len;

    logic       exp_stall, exp_busy;
    logic [2:0] exp_rs_d, exp_rt_d, exp_rs_e, exp_rt_e, exp_rt_m;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
        md_set = 1'b0;
        now    = 0;
    endtask

    function automatic int fwd(int r, int cons);
        int code;
        if (r == 0) return 0;
        for (int k = cons + 1; k < 3; k++) begin
            if (pipe[k].wa == r) begin
                if (k < pipe[k].tnew) return 0;
                if (cons < 0)       code = DTAB[k][pipe[k].res];
                else if (cons == 0) code = ETAB[k-1][pipe[k].res];
                else                code = MTAB[pipe[k].res];
                if (!MD_EN && ((cons < 0 && code >= 6) || (cons == 0 && code == 5))) code = 0;
                return code;
            end
        end
        return 0;
    endfunction

    function automatic bit needs_wait(int r, int tuse);
        if (r == 0 || tuse == 3) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (pipe[k].wa == r && tuse + k < pipe[k].tnew) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_eval();
        bit s;
        exp_busy = MD_EN && md_set && (now <= md_start + md_len);
        s = needs_wait(int'(rs_D), int'(tuseRs_D)) || needs_wait(int'(rt_D), int'(tuseRt_D));
        if (MD_EN && mdUse_D && (exp_busy || pipe[0].md)) s = 1'b1;
        exp_stall = s;
        exp_rs_d  = 3'(fwd(int'(rs_D), -1));
        exp_rt_d  = 3'(fwd(int'(rt_D), -1));
        exp_rs_e  = 3'(fwd(pipe[0].rs, 0));
        exp_rt_e  = 3'(fwd(pipe[0].rt, 0));
        exp_rt_m  = 3'(fwd(pipe[1].rt, 1));
    endtask

    task automatic model_advance();
        if (MD_EN && pipe[0].md) begin
            md_set   = 1'b1;
            md_start = now;
            md_len   = pipe[0].dv ? DIV : MULT;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (exp_stall) pipe[0] = '{default: 0};
        else pipe[0] = '{wa: int'(wa_D), tnew: int'(tnew_D), res: int'(resSrc_D),
                         rs: int'(rs_D), rt: int'(rt_D), md: MD_EN && mdStart_D, dv: mdDiv_D};
        now++;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_advance();
        #1;
    endtask

    task automatic set_d(input int rs, input int rt, input int tr, input int tt, input int wa,
                         input int tn, input int res, input bit ms, input bit mdv, input bit mu);
        rs_D = 5'(rs); rt_D = 5'(rt); tuseRs_D = 2'(tr); tuseRt_D = 2'(tt);
        wa_D = 5'(wa); tnew_D = 2'(tn); resSrc_D = 2'(res);
        mdStart_D = ms; mdDiv_D = mdv; mdUse_D = mu;
    endtask

    task automatic nop();
        set_d(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flush();
        nop();
        for (int i = 0; i < 14; i++) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        set_d(1, 1, 0, 0, 1, 3, 1, 1, 1, 1);
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
        checks++; if (mdBusy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", mdBusy); end
        checks++;
        if ({selRsD, selRtD, selRsE, selRtE, selRtM} !== 15'd0) begin
            errors++; $display("FAIL rst_sel got %h want 0", {selRsD, selRtD, selRsE, selRtE, selRtM});
        end
        tick(); tick();
        reset_n = 1'b1;
        nop();
    endtask

    task automatic test_alu_branch();
        flush();
        set_d(2, 3, 1, 1, 1, 1, 0, 0, 0, 0); tick();
        set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_stall got %b want 1", stall); end
        tick(); #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_release got %b want 0", stall); end
        checks++; if (selRsD !== 3'd3) begin errors++; $display("FAIL br_selRsD got %0d want 3", selRsD); end
        tick(); nop(); #2;
        checks++; if (selRsE !== 3'd4) begin errors++; $display("FAIL br_selRsE got %0d want 4", selRsE); end
        tick();
    endtask

    task automatic test_load_use();
        flush();
        set_d(29, 0, 1, 3, 2, 2, 2, 0, 0, 0); tick();
        set_d(2, 5, 1, 1, 3, 1, 0, 0, 0, 0); #2;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_stall got %b want 1", stall); end
        tick(); #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_release got %b want 0", stall); end
        checks++; if (selRsD !== 3'd0) begin errors++; $display("FAIL lw_selRsD got %0d want 0", selRsD); end
        tick(); nop(); #2;
        checks++; if (selRsE !== 3'd4) begin errors++; $display("FAIL lw_selRsE got %0d want 4", selRsE); end
        tick();
    endtask

    task automatic test_jal_jr();
        flush();
        set_d(0, 0, 3, 3, 31, 0, 1, 0, 0, 0); tick();
        set_d(31, 0, 0, 3, 0, 0, 0, 0, 0, 0); #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jr_stall got %b want 0", stall); end
        checks++; if (selRsD !== 3'd1) begin errors++; $display("FAIL jr_selRsD got %0d want 1", selRsD); end
        tick();
    endtask

    task automatic test_div_mflo();
        int n_stall, n_busy;
        bit done;
        n_stall = 0; n_busy = 0; done = 1'b0;
        flush();
        set_d(8, 9, 0, 0, 0, 0, 0, 1, 1, 0); tick();
        set_d(0, 0, 3, 3, 4, 1, 3, 0, 0, 1);
        for (int i = 0; i < 30 && !done; i++) begin
            #2;
            if (stall === 1'b1) begin
                n_stall++;
                if (mdBusy === 1'b1) n_busy++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL div_timeout stall still %b after 30 cycles", stall); end
        checks++;
        if (n_stall != (MD_EN ? 11 : 0)) begin
            errors++; $display("FAIL div_stall_cycles got %0d want %0d", n_stall, MD_EN ? 11 : 0);
        end
        checks++;
        if (n_busy != (MD_EN ? 10 : 0)) begin
            errors++; $display("FAIL div_busy_cycles got %0d want %0d", n_busy, MD_EN ? 10 : 0);
        end
        checks++; if (mdBusy !== 1'b0) begin errors++; $display("FAIL div_busy_end got %b want 0", mdBusy); end
        tick();
    endtask

    task automatic test_zero_reg();
        flush();
        for (int r = 0; r < 3; r++) begin
            set_d(0, 0, 0, 0, 0, 3, r, 0, 0, 0); tick();
        end
        for (int i = 0; i < 2; i++) begin
            set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall[%0d] got %b want 0", i, stall); end
            checks++;
            if ({selRsD, selRtD, selRsE, selRtE, selRtM} !== 15'd0) begin
                errors++;
                $display("FAIL zero_sel[%0d] got %h want 0", i, {selRsD, selRtD, selRsE, selRtE, selRtM});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_mult();
        flush();
        set_d(8, 9, 0, 0, 0, 0, 0, 1, 0, 0); tick();
        nop(); tick(); tick(); tick();
        set_d(0, 0, 3, 3, 5, 1, 3, 0, 0, 1); #2;
        checks++; if (mdBusy !== MD_EN) begin errors++; $display("FAIL mult_busy got %b want %b", mdBusy, MD_EN); end
        checks++; if (stall !== MD_EN) begin errors++; $display("FAIL mult_stall got %b want %b", stall, MD_EN); end
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (mdBusy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b want 0", mdBusy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mrst_stall got %b want 0", stall); end
        tick(); tick();
        reset_n = 1'b1;
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mrel_stall got %b want 0", stall); end
        checks++; if (mdBusy !== 1'b0) begin errors++; $display("FAIL mrel_busy got %b want 0", mdBusy); end
        tick();
        nop();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            set_d($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
            #2;
            model_eval();
            checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall c=%0d got %b want %b", c, stall, exp_stall); end
            checks++; if (mdBusy !== exp_busy) begin errors++; $display("FAIL rnd_busy c=%0d got %b want %b", c, mdBusy, exp_busy); end
            checks++; if (selRsD !== exp_rs_d) begin errors++; $display("FAIL rnd_selRsD c=%0d got %0d want %0d", c, selRsD, exp_rs_d); end
            checks++; if (selRtD !== exp_rt_d) begin errors++; $display("FAIL rnd_selRtD c=%0d got %0d want %0d", c, selRtD, exp_rt_d); end
            checks++; if (selRsE !== exp_rs_e) begin errors++; $display("FAIL rnd_selRsE c=%0d got %0d want %0d", c, selRsE, exp_rs_e); end
            checks++; if (selRtE !== exp_rt_e) begin errors++; $display("FAIL rnd_selRtE c=%0d got %0d want %0d", c, selRtE, exp_rt_e); end
            checks++; if (selRtM !== exp_rt_m) begin errors++; $display("FAIL rnd_selRtM c=%0d got %0d want %0d", c, selRtM, exp_rt_m); end
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        nop();
        test_reset();
        test_alu_branch();
        test_load_use();
        test_jal_jr();
        test_div_mflo();
        test_zero_reg();
        test_reset_mid_mult();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
